// File: rtl/tl_resp_pkg.sv
// Shared definitions for the TileLink SRAM responder.
//   - A-channel and D-channel opcode constants
//   - responder FSM state enum
//   - beat_count(): number of 64-bit beats for a given log2 size
package tl_resp_pkg;

    // A-channel opcodes
    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_ARITH       = 3'd2;
    localparam logic [2:0] OP_LOGICAL     = 3'd3;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_HINT        = 3'd5;

    // D-channel opcodes
    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
    localparam logic [2:0] D_HINT_ACK        = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2,
        ST_READ  = 2'd3
    } state_e;

    // Sub-word and single-word transfers take one beat; oversized requests
    // (size > 6) are errors but still consume a full 8-beat burst so the
    // handshake stays in step with the requester.
    function automatic logic [3:0] beat_count(input logic [3:0] size);
        if (size <= 4'd3)      return 4'd1;
        else if (size > 4'd6)  return 4'd8;
        else                   return 4'd1 << (size - 4'd3);
    endfunction

endpackage

// File: rtl/tl_resp_mem.sv
// Storage for the responder: DEPTH_WORDS x 64-bit words.
//   clock   : write and read both registered on the rising edge
//   wr_en   : write strobe; wr_mask selects byte lanes of wr_data
//   rd_addr : sampled every cycle; rd_data valid the following cycle
// Contents are never reset.
module tl_resp_mem #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_mask,
    input  logic [63:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [63:0]   rd_data
);

    logic [63:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_mask[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/tl_sram_responder.sv
// TileLink-UL style SRAM responder, one transaction outstanding.
//   clock, reset (async, active low)
//   auto_in_a_* : request channel (Put/Get/Hint, bursts up to 8 beats)
//   auto_in_d_* : response channel (AccessAck / AccessAckData / HintAck)
// Requests outside the address window, oversized, or atomic (opcode 2/3,
// and the unused 6/7) are answered with denied=1; reads of such requests
// also flag corrupt and return zero data, and writes are dropped.
module tl_sram_responder
    import tl_resp_pkg::*;
#(
    parameter logic [30:0] BASE_ADDR   = 31'h1000_0000,
    parameter int          DEPTH_WORDS = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        auto_in_a_valid,
    output logic        auto_in_a_ready,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_param,
    input  logic [3:0]  auto_in_a_bits_size,
    input  logic [3:0]  auto_in_a_bits_source,
    input  logic [30:0] auto_in_a_bits_address,
    input  logic [7:0]  auto_in_a_bits_mask,
    input  logic [63:0] auto_in_a_bits_data,
    input  logic        auto_in_a_bits_corrupt,
    output logic        auto_in_d_valid,
    input  logic        auto_in_d_ready,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [1:0]  auto_in_d_bits_param,
    output logic [3:0]  auto_in_d_bits_size,
    output logic [3:0]  auto_in_d_bits_source,
    output logic        auto_in_d_bits_sink,
    output logic        auto_in_d_bits_denied,
    output logic [63:0] auto_in_d_bits_data,
    output logic        auto_in_d_bits_corrupt
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS * 8);

    state_e          state, state_d;
    logic [3:0]      beat_cnt, cnt_d;
    logic [3:0]      beats, beats_d;
    logic            err, err_d;
    logic            hint, hint_d;
    logic [3:0]      size_q, size_d;
    logic [3:0]      src_q, src_d;
    logic [AW-1:0]   word_base, base_d;

    logic            wr_en;
    logic [AW-1:0]   wr_addr, rd_addr;
    logic [63:0]     rd_data;

    // Decode of the request currently on the A channel (used in IDLE only).
    logic [31:0]     a_offset;
    logic            a_in_window;
    logic            a_bad_op;
    logic            a_err;
    logic [AW-1:0]   a_idx;
    logic [3:0]      a_beats;

    assign a_offset    = {1'b0, auto_in_a_bits_address} - {1'b0, BASE_ADDR};
    assign a_in_window = (auto_in_a_bits_address >= BASE_ADDR) && (a_offset < WIN_BYTES);
    assign a_bad_op    = (auto_in_a_bits_opcode == OP_ARITH) || (auto_in_a_bits_opcode == OP_LOGICAL) ||
                         (auto_in_a_bits_opcode > OP_HINT);
    assign a_err       = !a_in_window || (auto_in_a_bits_size > 4'd6) || a_bad_op;
    assign a_idx       = a_offset[AW+2:3];
    assign a_beats     = beat_count(auto_in_a_bits_size);

    logic unused_ok;
    assign unused_ok = ^{auto_in_a_bits_param, a_offset};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            beat_cnt  <= '0;
            beats     <= 4'd1;
            err       <= 1'b0;
            hint      <= 1'b0;
            size_q    <= '0;
            src_q     <= '0;
            word_base <= '0;
        end else begin
            state     <= state_d;
            beat_cnt  <= cnt_d;
            beats     <= beats_d;
            err       <= err_d;
            hint      <= hint_d;
            size_q    <= size_d;
            src_q     <= src_d;
            word_base <= base_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = beat_cnt;
        beats_d = beats;
        err_d   = err;
        hint_d  = hint;
        size_d  = size_q;
        src_d   = src_q;
        base_d  = word_base;
        wr_en   = 1'b0;
        wr_addr = word_base + AW'(beat_cnt);
        rd_addr = word_base + AW'(beat_cnt);
        unique case (state)
            ST_IDLE: begin
                if (auto_in_a_valid) begin
                    size_d  = auto_in_a_bits_size;
                    src_d   = auto_in_a_bits_source;
                    base_d  = a_idx;
                    err_d   = a_err;
                    beats_d = a_beats;
                    hint_d  = 1'b0;
                    cnt_d   = '0;
                    case (auto_in_a_bits_opcode)
                        OP_PUT_FULL, OP_PUT_PARTIAL: begin
                            wr_addr = a_idx;
                            wr_en   = !a_err && !auto_in_a_bits_corrupt;
                            if (a_beats == 4'd1) begin
                                state_d = ST_ACK;
                            end else begin
                                state_d = ST_WRITE;
                                cnt_d   = 4'd1;
                            end
                        end
                        OP_HINT: begin
                            hint_d  = 1'b1;
                            state_d = ST_ACK;
                        end
                        default: begin
                            // Get and all error opcodes answer with data beats;
                            // launch the first read now so beat 0 is ready next cycle.
                            state_d = ST_READ;
                            rd_addr = a_idx;
                        end
                    endcase
                end
            end
            ST_WRITE: begin
                if (auto_in_a_valid) begin
                    wr_en = !err && !auto_in_a_bits_corrupt;
                    if (beat_cnt == beats - 4'd1) begin
                        state_d = ST_ACK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = beat_cnt + 4'd1;
                    end
                end
            end
            ST_ACK: begin
                if (auto_in_d_ready) state_d = ST_IDLE;
            end
            ST_READ: begin
                // Hold the read address while stalled so rd_data stays stable;
                // advance it on the fire so the next beat streams without a bubble.
                if (auto_in_d_ready) begin
                    if (beat_cnt == beats - 4'd1) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = beat_cnt + 4'd1;
                        rd_addr = word_base + AW'(beat_cnt + 4'd1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    tl_resp_mem #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_mem (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_mask (auto_in_a_bits_mask),
        .wr_data (auto_in_a_bits_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    logic in_ack, in_read;
    assign in_ack  = (state == ST_ACK);
    assign in_read = (state == ST_READ);

    assign auto_in_a_ready        = (state == ST_IDLE) || (state == ST_WRITE);
    assign auto_in_d_valid        = in_ack || in_read;
    assign auto_in_d_bits_opcode  = in_read ? D_ACCESS_ACK_DATA :
                                    (in_ack && hint) ? D_HINT_ACK : D_ACCESS_ACK;
    assign auto_in_d_bits_param   = 2'd0;
    assign auto_in_d_bits_sink    = 1'b0;
    assign auto_in_d_bits_size    = auto_in_d_valid ? size_q : 4'd0;
    assign auto_in_d_bits_source  = auto_in_d_valid ? src_q : 4'd0;
    assign auto_in_d_bits_denied  = auto_in_d_valid && err;
    assign auto_in_d_bits_corrupt = in_read && err;
    assign auto_in_d_bits_data    = (in_read && !err) ? rd_data : 64'd0;

endmodule

// File: tb/tb_tl_sram_responder.sv
module tb_tl_sram_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [2:0]  a_opcode = '0;
    logic [2:0]  a_param = '0;
    logic [3:0]  a_size = '0;
    logic [3:0]  a_source = '0;
    logic [30:0] a_address = '0;
    logic [7:0]  a_mask = '0;
    logic [63:0] a_data = '0;
    logic        a_corrupt = 1'b0;
    logic        d_valid;
    logic        d_ready = 1'b0;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic [3:0]  d_source;
    logic        d_sink;
    logic        d_denied;
    logic [63:0] d_data;
    logic        d_corrupt;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    tl_sram_responder dut (
        .clock                  (clock),
        .reset                  (reset),
        .auto_in_a_valid        (a_valid),
        .auto_in_a_ready        (a_ready),
        .auto_in_a_bits_opcode  (a_opcode),
        .auto_in_a_bits_param   (a_param),
        .auto_in_a_bits_size    (a_size),
        .auto_in_a_bits_source  (a_source),
        .auto_in_a_bits_address (a_address),
        .auto_in_a_bits_mask    (a_mask),
        .auto_in_a_bits_data    (a_data),
        .auto_in_a_bits_corrupt (a_corrupt),
        .auto_in_d_valid        (d_valid),
        .auto_in_d_ready        (d_ready),
        .auto_in_d_bits_opcode  (d_opcode),
        .auto_in_d_bits_param   (d_param),
        .auto_in_d_bits_size    (d_size),
        .auto_in_d_bits_source  (d_source),
        .auto_in_d_bits_sink    (d_sink),
        .auto_in_d_bits_denied  (d_denied),
        .auto_in_d_bits_data    (d_data),
        .auto_in_d_bits_corrupt (d_corrupt)
    );

    // Present one A beat and hold it until it fires; returns at edge+1.
    task automatic send_a(input logic [2:0] op, input logic [3:0] sz, input logic [3:0] src,
                          input logic [30:0] addr, input logic [7:0] mask,
                          input logic [63:0] data, input logic cor);
        int n = 0;
        a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src;
        a_address = addr; a_mask = mask; a_data = data; a_corrupt = cor;
        while (!a_ready && n < 50) begin @(posedge clock); #1; n++; end
        if (!a_ready) begin
            checks++; failures++;
            $display("FAIL a_fire_timeout addr=%h", addr);
        end
        @(posedge clock); #1;
        a_valid = 1'b0; a_corrupt = 1'b0;
    endtask

    // Wait for a D beat, capture it, and accept it; returns at edge+1.
    task automatic recv_d(output logic [2:0] op, output logic den, output logic cor,
                          output logic [63:0] data, output logic [3:0] sz, output logic [3:0] src);
        int n = 0;
        while (!d_valid && n < 50) begin @(posedge clock); #1; n++; end
        if (!d_valid) begin
            checks++; failures++;
            $display("FAIL d_valid_timeout");
        end
        op = d_opcode; den = d_denied; cor = d_corrupt; data = d_data; sz = d_size; src = d_source;
        d_ready = 1'b1;
        @(posedge clock); #1;
        d_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL rst_a_ready got=%b exp=1", a_ready); end
        checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL rst_d_valid got=%b exp=0", d_valid); end
        checks++; if ({d_opcode, d_size, d_source, d_denied, d_corrupt} !== 13'd0) begin
            failures++; $display("FAIL rst_d_bits got=%h exp=0", {d_opcode, d_size, d_source, d_denied, d_corrupt}); end
        checks++; if (d_data !== 64'd0) begin failures++; $display("FAIL rst_d_data got=%h exp=0", d_data); end
        reset = 1'b1;
    endtask

    task automatic test_put_get();
        logic [2:0] op; logic den, cor; logic [63:0] dat; logic [3:0] sz, src;
        send_a(3'd0, 4'd3, 4'h3, 31'h1000_0008, 8'hFF, 64'h1122334455667788, 1'b0);
        checks++; if (d_valid !== 1'b1) begin failures++; $display("FAIL put_ack_latency got=%b exp=1", d_valid); end
        recv_d(op, den, cor, dat, sz, src);
        checks++; if ({op, den, sz, src} !== {3'd0, 1'b0, 4'd3, 4'h3}) begin
            failures++; $display("FAIL put_ack got=%h exp=%h", {op, den, sz, src}, {3'd0, 1'b0, 4'd3, 4'h3}); end
        send_a(3'd4, 4'd3, 4'h5, 31'h1000_0008, 8'hFF, 64'd0, 1'b0);
        checks++; if (d_valid !== 1'b1) begin failures++; $display("FAIL get_latency got=%b exp=1", d_valid); end
        checks++; if (d_param !== 2'd0 || d_sink !== 1'b0) begin failures++; $display("FAIL get_param_sink got=%b%b exp=0", d_param, d_sink); end
        recv_d(op, den, cor, dat, sz, src);
        checks++; if ({op, den, cor, sz, src} !== {3'd1, 1'b0, 1'b0, 4'd3, 4'h5}) begin
            failures++; $display("FAIL get_fields got=%h exp=%h", {op, den, cor, sz, src}, {3'd1, 1'b0, 1'b0, 4'd3, 4'h5}); end
        checks++; if (dat !== 64'h1122334455667788) begin failures++; $display("FAIL get_data got=%h exp=1122334455667788", dat); end
    endtask

    task automatic test_partial();
        logic [2:0] op; logic den, cor; logic [63:0] dat; logic [3:0] sz, src;
        send_a(3'd1, 4'd3, 4'h2, 31'h1000_0008, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 1'b0);
        recv_d(op, den, cor, dat, sz, src);
        checks++; if ({op, den} !== {3'd0, 1'b0}) begin failures++; $display("FAIL partial_ack got=%h exp=0", {op, den}); end
        send_a(3'd4, 4'd3, 4'h2, 31'h1000_0008, 8'hFF, 64'd0, 1'b0);
        recv_d(op, den, cor, dat, sz, src);
        checks++; if (dat !== 64'h11223344_BBBBBBBB) begin failures++; $display("FAIL partial_data got=%h exp=11223344bbbbbbbb", dat); end
    endtask

    task automatic test_burst_stall();
        logic [2:0] op; logic den, cor; logic [63:0] dat; logic [3:0] sz, src;
        logic        ph, sv, sden, scor;
        logic [2:0]  so; logic [3:0] ssz, ssrc; logic [63:0] sd;
        int got = 0;
        for (int i = 0; i < 8; i++) begin
            send_a(3'd0, 4'd6, 4'h1, 31'h1000_0040, 8'hFF, 64'(i), 1'b0);
            if (i == 3) begin
                checks++; if (a_ready !== 1'b1 || d_valid !== 1'b0) begin
                    failures++; $display("FAIL burst_write_mid got=%b%b exp=10", a_ready, d_valid); end
            end
        end
        checks++; if (d_valid !== 1'b1) begin failures++; $display("FAIL burst_ack_latency got=%b exp=1", d_valid); end
        recv_d(op, den, cor, dat, sz, src);
        checks++; if ({op, den, sz} !== {3'd0, 1'b0, 4'd6}) begin failures++; $display("FAIL burst_ack got=%h exp=%h", {op, den, sz}, {3'd0, 1'b0, 4'd6}); end
        send_a(3'd4, 4'd6, 4'h7, 31'h1000_0040, 8'hFF, 64'd0, 1'b0);
        ph = 1'b0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            d_ready = ph;
            sv = d_valid; sd = d_data; so = d_opcode; ssz = d_size; ssrc = d_source; sden = d_denied; scor = d_corrupt;
            @(posedge clock); #1;
            if (sv && ph) begin
                checks++; if (sd !== 64'(got) || so !== 3'd1 || ssrc !== 4'h7) begin
                    failures++; $display("FAIL stall_beat%0d got=%h/%0d exp=%h/1", got, sd, so, 64'(got)); end
                got++;
            end else if (sv) begin
                checks++;
                if ({d_valid, d_data, d_opcode, d_size, d_source, d_denied, d_corrupt} !== {1'b1, sd, so, ssz, ssrc, sden, scor}) begin
                    failures++; $display("FAIL stall_hold got=%h exp=%h", d_data, sd); end
            end
            ph = ~ph;
        end
        d_ready = 1'b0;
        checks++; if (got !== 8) begin failures++; $display("FAIL stall_count got=%0d exp=8", got); end
        checks++; if (d_valid !== 1'b0 || a_ready !== 1'b1) begin failures++; $display("FAIL stall_end got=%b%b exp=01", d_valid, a_ready); end
    endtask

    task automatic test_back_to_back();
        send_a(3'd4, 4'd6, 4'h4, 31'h1000_0040, 8'hFF, 64'd0, 1'b0);
        d_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (d_valid !== 1'b1 || d_data !== 64'(i)) begin
                failures++; $display("FAIL b2b_beat%0d got=%b/%h exp=1/%h", i, d_valid, d_data, 64'(i)); end
            @(posedge clock); #1;
        end
        d_ready = 1'b0;
        checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", d_valid); end
    endtask

    task automatic test_errors();
        logic [2:0] op; logic den, cor; logic [63:0] dat; logic [3:0] sz, src;
        send_a(3'd4, 4'd4, 4'h6, 31'h0000_0000, 8'hFF, 64'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            recv_d(op, den, cor, dat, sz, src);
            checks++; if ({op, den, cor} !== {3'd1, 1'b1, 1'b1} || dat !== 64'd0) begin
                failures++; $display("FAIL err_get_beat%0d got=%h/%h exp=7/0", i, {op, den, cor}, dat); end
        end
        checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL err_get_count got=%b exp=0", d_valid); end
        send_a(3'd4, 4'd3, 4'h6, 31'h1000_0008, 8'hFF, 64'd0, 1'b0);
        recv_d(op, den, cor, dat, sz, src);
        checks++; if (den !== 1'b0 || dat !== 64'h11223344_BBBBBBBB) begin
            failures++; $display("FAIL err_recover got=%b/%h exp=0/11223344bbbbbbbb", den, dat); end
        send_a(3'd2, 4'd3, 4'h1, 31'h1000_0008, 8'hFF, 64'd0, 1'b0);
        recv_d(op, den, cor, dat, sz, src);
        checks++; if ({op, den, cor} !== {3'd1, 1'b1, 1'b1}) begin failures++; $display("FAIL err_arith got=%h exp=7", {op, den, cor}); end
        send_a(3'd5, 4'd3, 4'h9, 31'h1000_0008, 8'hFF, 64'd0, 1'b0);
        recv_d(op, den, cor, dat, sz, src);
        checks++; if ({op, den, src} !== {3'd2, 1'b0, 4'h9}) begin failures++; $display("FAIL hint_ack got=%h exp=%h", {op, den, src}, {3'd2, 1'b0, 4'h9}); end
    endtask

    task automatic test_boundary();
        logic [2:0] op; logic den, cor; logic [63:0] dat; logic [3:0] sz, src;
        send_a(3'd0, 4'd3, 4'h0, 31'h1000_01F8, 8'hFF, 64'h0000_0000_0000_CAFE, 1'b0);
        recv_d(op, den, cor, dat, sz, src);
        checks++; if (den !== 1'b0) begin failures++; $display("FAIL top_word_ack got=%b exp=0", den); end
        send_a(3'd4, 4'd3, 4'h0, 31'h1000_01F8, 8'hFF, 64'd0, 1'b0);
        recv_d(op, den, cor, dat, sz, src);
        checks++; if (dat !== 64'hCAFE) begin failures++; $display("FAIL top_word_data got=%h exp=cafe", dat); end
        send_a(3'd0, 4'd3, 4'h0, 31'h1000_0200, 8'hFF, 64'hBAD, 1'b0);
        recv_d(op, den, cor, dat, sz, src);
        checks++; if ({op, den} !== {3'd0, 1'b1}) begin failures++; $display("FAIL above_window got=%h exp=1", {op, den}); end
        send_a(3'd4, 4'd3, 4'h0, 31'h0FFF_FFF8, 8'hFF, 64'd0, 1'b0);
        recv_d(op, den, cor, dat, sz, src);
        checks++; if ({den, cor} !== 2'b11) begin failures++; $display("FAIL below_window got=%b exp=11", {den, cor}); end
    endtask

    task automatic test_corrupt();
        logic [2:0] op; logic den, cor; logic [63:0] dat; logic [3:0] sz, src;
        send_a(3'd0, 4'd3, 4'h0, 31'h1000_0010, 8'hFF, 64'h55, 1'b0);
        recv_d(op, den, cor, dat, sz, src);
        send_a(3'd0, 4'd3, 4'h0, 31'h1000_0010, 8'hFF, 64'hDEAD, 1'b1);
        recv_d(op, den, cor, dat, sz, src);
        checks++; if ({op, den} !== {3'd0, 1'b0}) begin failures++; $display("FAIL corrupt_ack got=%h exp=0", {op, den}); end
        send_a(3'd4, 4'd3, 4'h0, 31'h1000_0010, 8'hFF, 64'd0, 1'b0);
        recv_d(op, den, cor, dat, sz, src);
        checks++; if (dat !== 64'h55) begin failures++; $display("FAIL corrupt_nowrite got=%h exp=55", dat); end
    endtask

    task automatic test_reset_mid();
        logic [2:0] op; logic den, cor; logic [63:0] dat; logic [3:0] sz, src;
        send_a(3'd4, 4'd6, 4'h2, 31'h1000_0040, 8'hFF, 64'd0, 1'b0);
        d_ready = 1'b1;
        repeat (3) begin @(posedge clock); #1; end
        d_ready = 1'b0;
        checks++; if (d_valid !== 1'b1 || d_data !== 64'd3) begin failures++; $display("FAIL rmid_beat3 got=%b/%h exp=1/3", d_valid, d_data); end
        reset = 1'b0;
        #1;
        checks++; if (d_valid !== 1'b0 || a_ready !== 1'b1) begin failures++; $display("FAIL rmid_in_reset got=%b%b exp=01", d_valid, a_ready); end
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        checks++; if (d_valid !== 1'b0 || a_ready !== 1'b1) begin failures++; $display("FAIL rmid_after got=%b%b exp=01", d_valid, a_ready); end
        send_a(3'd4, 4'd3, 4'h8, 31'h1000_0048, 8'hFF, 64'd0, 1'b0);
        recv_d(op, den, cor, dat, sz, src);
        checks++; if ({op, den, src} !== {3'd1, 1'b0, 4'h8} || dat !== 64'd1) begin
            failures++; $display("FAIL rmid_new_get got=%h/%h exp=%h/1", {op, den, src}, dat, {3'd1, 1'b0, 4'h8}); end
    endtask

    initial begin
        test_reset();
        test_put_get();
        test_partial();
        test_burst_stall();
        test_back_to_back();
        test_errors();
        test_boundary();
        test_corrupt();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
